counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Run/pause/stop sequencer for the prescaled 4-bit display counter used in the lab designs.
- Owns the prescaler and the count register.
- Replaces the derived-clock scheme with a single-clock, tick-enable datapath.
- Accepts pre-debounced single-cycle button pulses and drives Count to the 7-seg/LED stage. Tick, Done and State go to status LEDs.

Parameters:
- DIV_MAX, 99_999_999, prescaler terminal value; one Tick every DIV_MAX+1 Clk cycles while running (1 Hz at 100 MHz).
- DIV_WIDTH, 27, prescaler width; must hold DIV_MAX.
- CNT_WIDTH, 4, count width.

Ports:
- Clk  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous, active-high; highest priority
- Start  in  1  pulse: begin/resume/restart counting
- Stop  in  1  pulse: pause counting
- Clear  in  1  pulse: abort to IDLE, zero count
- Load  in  1  pulse: Count <= Load_Val
- Load_Val  in  CNT_WIDTH  preset value
- Up  in  1  1 = count up, 0 = count down; sampled on every Tick
- Wrap  in  1  1 = wrap at terminal and keep running, 0 = stop in DONE
- Limit  in  CNT_WIDTH  up-count terminal value
- Count  out  CNT_WIDTH  registered count
- Tick  out  1  registered, one-cycle pulse per prescaler wrap
- Done  out  1  registered level, high only in DONE
- State  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Reset (sync, active-high): State=IDLE, Count=0, Div_Cnt=0, Tick=0, Done=0.
- Command priority per cycle: Reset > Clear > Load > Stop > Start. Lower-priority commands in the same cycle are ignored.
- Prescaler:
  - Div_Cnt increments only in RUN.
  - When Div_Cnt==DIV_MAX: Div_Cnt <= 0 and Tick=1 in the next cycle.
  - Held in PAUSE; cleared in IDLE and DONE, and on Load.
- Count update on a RUN-state tick event (Div_Cnt==DIV_MAX), same edge:
  - Up=1, Count>=Limit: Wrap=1 -> Count <= 0, stay RUN; Wrap=0 -> Count unchanged, go DONE.
  - Up=1, otherwise: Count <= Count+1.
  - Up=0, Count==0: Wrap=1 -> Count <= Limit, stay RUN; Wrap=0 -> Count unchanged, go DONE.
  - Up=0, otherwise: Count <= Count-1.
  - No arithmetic overflow: Count never exceeds max(Limit, Load_Val).
- Transitions:
  - IDLE: Start -> RUN.
  - RUN: Stop -> PAUSE.
  - PAUSE: Start -> RUN, prescaler resumes from its held value; Stop is ignored.
  - DONE: Start -> RUN with Count <= 0 if Up=1, else Limit; Div_Cnt=0.
  - Clear from any state -> IDLE, Count=0, Div_Cnt=0.
- Load in any state: Count <= Load_Val, Div_Cnt <= 0, state unchanged except DONE -> IDLE.
- Stop coincident with a tick event: the count update and Tick still occur, Div_Cnt wraps to 0, then state goes PAUSE.
- Limit=0 with Up=1: the first tick hits the terminal condition.
- Limit changed mid-run: takes effect at the next tick.
- Reset mid-run: all registers return to reset values at that edge; no residual Tick.
- Done = (State==DONE), registered, so it rises on the same edge as the DONE transition.

Decomposition:
- Shared package counter_pkg holds the state encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE) and the default DIV_MAX, CNT_WIDTH and DIV_WIDTH constants for reuse by display/top modules.
- One sub-module is natural: tick_prescaler (Clk, Reset, En, Clr, Tick_Evt), i.e. the DIV_MAX counter with hold and clear.
- The FSM and count register stay in counter_seq_ctrl.

Test Plan (DIV_MAX=3, CNT_WIDTH=4):
- Reset, Start, Up=1, Wrap=1, Limit=9 -> Tick every 4 cycles; Count 0,1,...,9,0; State=01 throughout.
- Up=1, Wrap=0, Limit=5, Start -> Count reaches 5; on the next tick State=11, Done=1, Count holds 5; Start -> Count=0, RUN.
- RUN at Count=3 with Div_Cnt=2, Stop -> PAUSE; wait 20 cycles, Count stays 3; Start -> next Tick after 2 cycles, Count=4.
- Load_Val=7, Load in RUN, Up=0, Wrap=1, Limit=9 -> Count 7,6,...,0,9,8; Load coincident with Start in IDLE -> Load wins, stays IDLE.
- Stop on the same cycle as a tick event at Count=2 (Up=1) -> Count=3, Tick pulses, State=PAUSE, Div_Cnt=0.
- Reset asserted mid-RUN at Count=6 -> next cycle Count=0, State=00, Tick=0, Done=0; Clear in DONE -> IDLE, Count=0.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared definitions for the prescaled display counter:
//                sequencer state encoding and default sizing constants
//                reused by the sequencer, prescaler and display/top modules.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

  // Sequencer states. The encoding is visible on the State status LEDs,
  // so the values are fixed rather than left to the enum defaults.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Defaults: one tick per second from a 100 MHz board clock.
  localparam int C_DIV_MAX_DEF   = 99_999_999;
  localparam int C_DIV_WIDTH_DEF = 27;
  localparam int C_CNT_WIDTH_DEF = 4;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_seq_ctrl_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divide-by-(DIV_MAX+1) counter with hold and
//                clear. Produces a combinational tick event on the cycle the
//                counter sits at DIV_MAX while enabled; the counter wraps to
//                zero on that same edge.
//  Ports       : clk_i      - system clock
//                reset_i    - synchronous active-high reset
//                en_i       - count enable (hold when low)
//                clr_i      - synchronous clear, overrides en_i
//                tick_evt_o - terminal-count event (same cycle as DIV_MAX)
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
  parameter int DIV_MAX   = 99_999_999,
  parameter int DIV_WIDTH = 27
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_evt_o
);

  localparam logic [DIV_WIDTH-1:0] c_div_max = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_d;
  logic                 w_at_max;

  assign w_at_max = (div_q == c_div_max);

  // A clear (Load/Clear command or leaving RUN for IDLE/DONE) cancels a
  // pending event: the count register is being overwritten that cycle.
  assign tick_evt_o = en_i & ~clr_i & w_at_max;

  always_comb begin
    div_d = div_q;
    if (clr_i) begin
      div_d = '0;
    end else if (en_i) begin
      div_d = w_at_max ? '0 : div_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_ctrl
//  Description : Run/pause/stop sequencer for the prescaled display counter.
//                Single-clock design: the prescaler produces a tick enable
//                and the count register advances on that enable. Button
//                inputs are pre-debounced one-cycle pulses.
//  Ports       : clk_i       - system clock, all logic on posedge
//                reset_i     - synchronous active-high reset, top priority
//                start_i     - begin / resume / restart counting
//                stop_i      - pause counting
//                clear_i     - abort to IDLE, zero count
//                load_i      - preset count from load_val_i
//                load_val_i  - preset value
//                up_i        - 1 = count up, 0 = count down
//                wrap_i      - 1 = wrap at terminal, 0 = stop in DONE
//                limit_i     - up-count terminal / down-count reload value
//                count_o     - registered count
//                tick_o      - registered one-cycle pulse per prescaler wrap
//                done_o      - registered, high only in DONE
//                state_o     - IDLE=00 RUN=01 PAUSE=10 DONE=11
//  Revision    : 1.0  initial release
// ============================================================================
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int DIV_MAX   = C_DIV_MAX_DEF,
  parameter int DIV_WIDTH = C_DIV_WIDTH_DEF,
  parameter int CNT_WIDTH = C_CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 up_i,
  input  logic                 wrap_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 tick_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 tick_q,  tick_d;
  logic                 done_q,  done_d;

  logic                 w_presc_en;
  logic                 w_presc_clr;
  logic                 w_tick_evt;
  logic                 w_terminal;

  // --------------------------------------------------------------------------
  // Prescaler control: runs only in RUN, holds in PAUSE, and is kept at zero
  // in IDLE/DONE so a Start from either always begins a full tick period.
  // --------------------------------------------------------------------------
  assign w_presc_en  = (state_q == ST_RUN);
  assign w_presc_clr = clear_i | load_i |
                       (state_q == ST_IDLE) | (state_q == ST_DONE);

  tick_prescaler #(
    .DIV_MAX   (DIV_MAX),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_prescaler (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (w_presc_en),
    .clr_i      (w_presc_clr),
    .tick_evt_o (w_tick_evt)
  );

  // Terminal condition is direction dependent: the top end is Limit (and
  // anything above it, e.g. after a Load), the bottom end is zero.
  assign w_terminal = up_i ? (count_q >= limit_i) : (count_q == '0);

  // --------------------------------------------------------------------------
  // Next-state / next-count logic. Command priority below Reset:
  // Clear > Load > Stop > Start.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;

    if (clear_i) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_tick_evt) begin
            tick_d = 1'b1;
            if (w_terminal) begin
              if (wrap_i) begin
                count_d = up_i ? '0 : limit_i;
              end
            end else begin
              count_d = up_i ? count_q + CNT_WIDTH'(1)
                             : count_q - CNT_WIDTH'(1);
            end
          end
          // A coincident Stop still lets the tick update land, then pauses;
          // the terminal is re-evaluated on the first tick after resuming.
          if (stop_i) begin
            state_d = ST_PAUSE;
          end else if (w_tick_evt && w_terminal && !wrap_i) begin
            state_d = ST_DONE;
          end
        end

        ST_PAUSE: begin
          if (start_i) begin
            state_d = ST_RUN;
          end
        end

        ST_DONE: begin
          if (start_i) begin
            state_d = ST_RUN;
            count_d = up_i ? '0 : limit_i;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule : counter_seq_ctrl
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_seq_ctrl
//  Description : Self-checking bench for counter_seq_ctrl with DIV_MAX=3.
//                Directed scenarios followed by randomized button traffic,
//                every cycle compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_seq_ctrl;

  localparam int DIV_MAX   = 3;
  localparam int DIV_WIDTH = 4;
  localparam int CNT_WIDTH = 4;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic                 clk;
  logic                 reset;
  logic                 start, stop, clear, load;
  logic [CNT_WIDTH-1:0] load_val;
  logic                 up, wrap;
  logic [CNT_WIDTH-1:0] limit;
  logic [CNT_WIDTH-1:0] count;
  logic                 tick, done;
  logic [1:0]           state;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_state = S_IDLE;
  int m_count = 0;
  int m_div   = 0;
  int m_tick  = 0;

  counter_seq_ctrl #(
    .DIV_MAX   (DIV_MAX),
    .DIV_WIDTH (DIV_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .stop_i     (stop),
    .clear_i    (clear),
    .load_i     (load),
    .load_val_i (load_val),
    .up_i       (up),
    .wrap_i     (wrap),
    .limit_i    (limit),
    .count_o    (count),
    .tick_o     (tick),
    .done_o     (done),
    .state_o    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of the specification's rules applied to the model.
  task automatic model_step();
    int lim;
    bit ev;
    lim = int'(limit);
    ev  = (m_state == S_RUN) && (m_div == DIV_MAX) && !clear && !load;
    m_tick = 0;
    if (reset) begin
      m_state = S_IDLE; m_count = 0; m_div = 0;
    end else if (clear) begin
      m_state = S_IDLE; m_count = 0; m_div = 0;
    end else if (load) begin
      m_count = int'(load_val); m_div = 0;
      if (m_state == S_DONE) m_state = S_IDLE;
    end else if (m_state == S_IDLE) begin
      m_div = 0;
      if (start) m_state = S_RUN;
    end else if (m_state == S_RUN) begin
      bit finished;
      finished = 0;
      if (ev) begin
        m_tick = 1;
        m_div  = 0;
        if (up && m_count >= lim) begin
          if (wrap) m_count = 0; else finished = 1;
        end else if (!up && m_count == 0) begin
          if (wrap) m_count = lim; else finished = 1;
        end else begin
          m_count = up ? m_count + 1 : m_count - 1;
        end
      end else begin
        m_div = m_div + 1;
      end
      if (stop) m_state = S_PAUSE;
      else if (finished) m_state = S_DONE;
    end else if (m_state == S_PAUSE) begin
      if (start) m_state = S_RUN;
    end else begin
      m_div = 0;
      if (start) begin
        m_state = S_RUN;
        m_count = up ? 0 : lim;
      end
    end
  endtask

  task automatic check_all(input string tag);
    checks += 4;
    assert (count === CNT_WIDTH'(m_count)) else begin
      errors++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, count, m_count);
    end
    assert (tick === 1'(m_tick)) else begin
      errors++;
      $error("FAIL %s tick observed=%0b expected=%0d", tag, tick, m_tick);
    end
    assert (state === 2'(m_state)) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, m_state);
    end
    assert (done === (m_state == S_DONE)) else begin
      errors++;
      $error("FAIL %s done observed=%0b expected=%0b", tag, done, m_state == S_DONE);
    end
  endtask

  // Apply one cycle of inputs (pulses given as arguments, levels taken from
  // the current up/wrap/limit/load_val), advance model and compare.
  task automatic cyc(input string tag, input logic rs, input logic s,
                     input logic p, input logic c, input logic l);
    reset = rs; start = s; stop = p; clear = c; load = l;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; clear = 0; load = 0;
    load_val = '0; up = 1; wrap = 1; limit = 4'd9;

    // Reset state
    cyc("reset", 1, 0, 0, 0, 0);
    cyc("reset", 1, 0, 0, 0, 0);
    checks += 2;
    assert (count === 4'd0 && state === 2'b00) else begin
      errors++;
      $error("FAIL reset_const count=%0d state=%0d expected 0/0", count, state);
    end
    assert (tick === 1'b0 && done === 1'b0) else begin
      errors++;
      $error("FAIL reset_const tick=%0b done=%0b expected 0/0", tick, done);
    end

    // Up, wrap at 9: full cycle 0..9,0
    cyc("start_up", 0, 1, 0, 0, 0);
    idle("run_wrap", 4 * 11);

    // Up, no wrap, Limit=5: reach DONE, then restart
    wrap = 0; limit = 4'd5;
    cyc("clr", 0, 0, 0, 1, 0);
    cyc("start5", 0, 1, 0, 0, 0);
    idle("to_done", 4 * 7);
    checks++;
    assert (state === 2'b11 && count === 4'd5) else begin
      errors++;
      $error("FAIL done_hold state=%0d count=%0d expected 3/5", state, count);
    end
    cyc("restart", 0, 1, 0, 0, 0);
    idle("rerun", 6);

    // Pause mid-period and resume
    wrap = 1; limit = 4'd9;
    cyc("clr2", 0, 0, 0, 1, 0);
    cyc("start3", 0, 1, 0, 0, 0);
    idle("to3", 4 * 3 + 2);
    cyc("stop", 0, 0, 1, 0, 0);
    idle("paused", 20);
    cyc("stop_in_pause", 0, 0, 1, 0, 0);
    cyc("resume", 0, 1, 0, 0, 0);
    idle("resumed", 6);

    // Load then count down with wrap to Limit
    load_val = 4'd7; up = 0;
    cyc("load_run", 0, 0, 0, 0, 1);
    idle("down", 4 * 11);

    // Load coincident with Start in IDLE: Load wins
    cyc("clr3", 0, 0, 0, 1, 0);
    load_val = 4'd4;
    cyc("load_start", 0, 1, 0, 0, 1);
    idle("stay_idle", 3);

    // Stop coincident with tick at Count=2
    up = 1; load_val = 4'd2;
    cyc("load2", 0, 0, 0, 0, 1);
    cyc("start2", 0, 1, 0, 0, 0);
    idle("pre_tick", 3);
    cyc("stop_tick", 0, 0, 1, 0, 0);
    idle("after_stop_tick", 3);
    cyc("resume2", 0, 1, 0, 0, 0);
    idle("full_period", 4);

    // Limit=0 up: first tick hits terminal
    limit = 4'd0; wrap = 0;
    cyc("clr4", 0, 0, 0, 1, 0);
    cyc("start_lim0", 0, 1, 0, 0, 0);
    idle("lim0", 5);

    // Reset mid-run, and Clear in DONE
    limit = 4'd9; wrap = 1;
    cyc("restart6", 0, 1, 0, 0, 0);
    idle("to6", 4 * 6 + 1);
    cyc("reset_mid", 1, 0, 0, 0, 0);
    limit = 4'd1; wrap = 0;
    cyc("start_done", 0, 1, 0, 0, 0);
    idle("to_done2", 12);
    cyc("clear_done", 0, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rs, s, p, c, l;
      rs = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 11) == 0);
      c  = ($urandom_range(0, 59) == 0);
      l  = ($urandom_range(0, 39) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) up = ~up;
      if ($urandom_range(0, 29) == 0) wrap = ~wrap;
      if ($urandom_range(0, 39) == 0) limit = 4'($urandom_range(0, 15));
      cyc("rand", rs, s, p, c, l);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_counter_seq_ctrl
`default_nettype wire
